// File: rtl/uart_tx_fifo_param_if.sv
// Host-side bundle for the UART transmitter: configuration, FIFO write port, status and serial line.
// Latency: none (wires only).
// Backpressure: the host must watch full; writes while full are dropped and flagged by overflow.
//
// Signals (slave = transmitter side):
//   cfg_div/cfg_parity/cfg_stop2  in   frame configuration, latched at each frame start
//   wr_en/wr_data                 in   FIFO push
//   full/empty/level/overflow     out  FIFO status
//   tx/busy/frame_done            out  serial line and frame status
//   brk_req                       in   break request, present only with UART_TX_BREAK_EN defined
interface uart_tx_fifo_param_if #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [DIV_W-1:0]  cfg_div;
    logic [1:0]        cfg_parity;
    logic              cfg_stop2;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              empty;
    logic [LVL_W-1:0]  level;
    logic              overflow;
    logic              tx;
    logic              busy;
    logic              frame_done;
`ifdef UART_TX_BREAK_EN
    logic              brk_req;
`endif

    modport master (
`ifdef UART_TX_BREAK_EN
        output brk_req,
`endif
        output cfg_div, cfg_parity, cfg_stop2, wr_en, wr_data,
        input  full, empty, level, overflow, tx, busy, frame_done
    );

    modport slave (
`ifdef UART_TX_BREAK_EN
        input  brk_req,
`endif
        input  cfg_div, cfg_parity, cfg_stop2, wr_en, wr_data,
        output full, empty, level, overflow, tx, busy, frame_done
    );
endinterface

// File: rtl/uart_tx_fifo_param.sv
// UART transmitter with write-side FIFO, bit-period clock enable, runtime parity/stop selection.
// Latency: write into empty FIFO with FSM idle -> pop next cycle -> start bit on tx the cycle after.
// Backpressure: FIFO full drops the write and pulses overflow; frames chain back-to-back while FIFO non-empty.
//
// Ports: clk_i (clock), rst_i (synchronous active-high reset), bus (uart_tx_fifo_param_if.slave).
// Optional feature: define UART_TX_BREAK_EN to add bus.brk_req and the line-break states.
// Frame: start(0), DATA_W bits LSB first, optional parity, 1 or 2 stop bits; each bit cfg_div+1 clocks.
module uart_tx_fifo_param #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input logic                 clk_i,
    input logic                 rst_i,
    uart_tx_fifo_param_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(DATA_W);
    localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
`ifdef UART_TX_BREAK_EN
        ,
        S_BREAK,
        S_BRK_GAP
`endif
    } state_t;

    // ---------------------------------------------------------------- FIFO
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [LW-1:0]     level_q;
    logic              full, empty, push, pop;
    logic [DATA_W-1:0] head;

    assign full  = (level_q == DEPTH_L);
    assign empty = (level_q == '0);
    // A write while full is dropped even if the FSM pops in the same cycle.
    assign push  = bus.wr_en && !full;
    assign head  = mem_q[rptr_q];

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // ---------------------------------------------------------------- FSM
    state_t            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              stop_q, stop_d;
    logic              stop2_q, stop2_d;
    logic              par_en_q, par_en_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              bit_end;
    logic              frame_done_c;

    assign bit_end = (cnt_q == div_q);

    always_comb begin
        state_d      = state_q;
        cnt_d        = bit_end ? '0 : cnt_q + DIV_W'(1);
        div_d        = div_q;
        sh_d         = sh_q;
        bit_d        = bit_q;
        stop_d       = stop_q;
        stop2_d      = stop2_q;
        par_en_d     = par_en_q;
        par_d        = par_q;
        tx_d         = tx_q;
        pop          = 1'b0;
        frame_done_c = 1'b0;

        // tx_d always reflects the bit of the state being entered, so the
        // registered line changes on the same edge as the state.
        case (state_q)
            S_IDLE: begin
                tx_d  = 1'b1;
                cnt_d = '0;
`ifdef UART_TX_BREAK_EN
                if (bus.brk_req) begin
                    state_d = S_BREAK;
                    tx_d    = 1'b0;
                    div_d   = bus.cfg_div;
                end else
`endif
                if (!empty) begin
                    pop = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    tx_d    = sh_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == LAST_BIT) begin
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            stop_d  = 1'b0;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        sh_d  = sh_q >> 1;
                        tx_d  = sh_q[1];
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    stop_d  = 1'b0;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (stop2_q && !stop_q) begin
                        stop_d = 1'b1;
                    end else begin
                        frame_done_c = 1'b1;
                        state_d      = S_IDLE;
`ifdef UART_TX_BREAK_EN
                        // A pending break wins over the next queued frame.
                        if (bus.brk_req) begin
                            state_d = S_BREAK;
                            tx_d    = 1'b0;
                            div_d   = bus.cfg_div;
                        end else
`endif
                        if (!empty) begin
                            pop = 1'b1;
                        end
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            S_BREAK: begin
                tx_d  = 1'b0;
                cnt_d = '0;
                if (!bus.brk_req) begin
                    state_d = S_BRK_GAP;
                    tx_d    = 1'b1;
                end
            end
            S_BRK_GAP: begin
                // One full bit period of mark before anything else may start.
                tx_d = 1'b1;
                if (bit_end) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Frame start: configuration is captured here and held for the whole frame.
        if (pop) begin
            state_d  = S_START;
            tx_d     = 1'b0;
            cnt_d    = '0;
            bit_d    = '0;
            stop_d   = 1'b0;
            sh_d     = head;
            div_d    = bus.cfg_div;
            stop2_d  = bus.cfg_stop2;
            par_en_d = (bus.cfg_parity == 2'b01) || (bus.cfg_parity == 2'b10);
            par_d    = (bus.cfg_parity == 2'b01) ? ~^head : ^head;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            div_q    <= '0;
            sh_q     <= '0;
            bit_q    <= '0;
            stop_q   <= 1'b0;
            stop2_q  <= 1'b0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            sh_q     <= sh_d;
            bit_q    <= bit_d;
            stop_q   <= stop_d;
            stop2_q  <= stop2_d;
            par_en_q <= par_en_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
        end
    end

    // ---------------------------------------------------------------- outputs
    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.level      = level_q;
    assign bus.overflow   = bus.wr_en && full;
    assign bus.tx         = tx_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.frame_done = frame_done_c;
endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Self-checking bench for uart_tx_fifo_param: directed steps plus randomized frames,
// each compared against a per-frame bit list built from the frame rules.
module tb_uart_tx_fifo_param;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int DIV_W      = 16;
    localparam int BUDGET     = 2000;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    uart_tx_fifo_param_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) bus ();

    uart_tx_fifo_param #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int div, input int par, input int s2);
        bus.cfg_div    = div[DIV_W-1:0];
        bus.cfg_parity = par[1:0];
        bus.cfg_stop2  = s2[0];
    endtask

    // One isolated write; returns on the negedge right after the capturing edge.
    task automatic push(input logic [DATA_W-1:0] d);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    // mode 0: wait (bounded) for the start bit; mode 1: start bit must appear
    // on the next sample; mode 2: the current sample is already the start bit.
    task automatic check_frame(input logic [DATA_W-1:0] d, input int div, input int par,
                               input int s2, input int mode);
        int bits[$];
        int ones;
        int w;
        ones = 0;
        bits.push_back(0);
        for (int i = 0; i < DATA_W; i++) begin
            bits.push_back(int'(d[i]));
            ones += int'(d[i]);
        end
        if (par == 1) bits.push_back(1 - (ones % 2));   // odd: total count of ones odd
        if (par == 2) bits.push_back(ones % 2);         // even: total count of ones even
        bits.push_back(1);
        if (s2 != 0) bits.push_back(1);

        if (mode == 1) begin
            chk("pre_start_idle", 32'(bus.tx), 32'd1);
            @(negedge clk);
            chk("start_latency", 32'(bus.tx), 32'd0);
        end else if (mode == 0) begin
            w = 0;
            while (bus.tx !== 1'b0 && w < BUDGET) begin
                @(negedge clk);
                w++;
            end
            chk("start_wait", 32'(bus.tx), 32'd0);
        end else begin
            chk("start_now", 32'(bus.tx), 32'd0);
        end

        for (int b = 0; b < bits.size(); b++) begin
            for (int c = 0; c <= div; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                chk("tx_bit", 32'(bus.tx), 32'(bits[b]));
                chk("busy_in_frame", 32'(bus.busy), 32'd1);
                chk("frame_done", 32'(bus.frame_done), 32'(b == bits.size() - 1 && c == div));
            end
        end
    endtask

    task automatic check_idle();
        @(negedge clk);
        chk("idle_tx", 32'(bus.tx), 32'd1);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_empty", 32'(bus.empty), 32'd1);
        chk("idle_level", 32'(bus.level), 32'd0);
        chk("idle_done", 32'(bus.frame_done), 32'd0);
    endtask

    initial begin
        logic [DATA_W-1:0] x, a, b, c, d, e;
        logic [DATA_W-1:0] burst [17];
        int div, par, s2;

        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
`ifdef UART_TX_BREAK_EN
        bus.brk_req = 1'b0;
`endif
        set_cfg(3, 0, 0);
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_tx", 32'(bus.tx), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.frame_done), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_level", 32'(bus.level), 32'd0);
        rst = 1'b0;

        // 0xA5, 4 clk/bit, no parity, 1 stop: 40-clk frame
        set_cfg(3, 0, 0);
        push(8'hA5);
        check_frame(8'hA5, 3, 0, 0, 1);
        check_idle();

        // Even then odd parity on 0x07, two stop bits
        set_cfg(1, 2, 1);
        push(8'h07);
        check_frame(8'h07, 1, 2, 1, 1);
        check_idle();
        set_cfg(1, 1, 1);
        push(8'h07);
        check_frame(8'h07, 1, 1, 1, 1);
        check_idle();

        // 17-word burst while a frame is in flight: 16 queued, 17th overflows
        set_cfg(3, 0, 0);
        x = DATA_W'($urandom);
        for (int i = 0; i < 17; i++) burst[i] = DATA_W'($urandom);
        push(x);
        fork
            begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 17; i++) begin
                    bus.wr_en   = 1'b1;
                    bus.wr_data = burst[i];
                    #1;
                    chk("burst_level", 32'(bus.level), 32'(i));
                    chk("burst_full", 32'(bus.full), 32'(i == 16));
                    chk("burst_overflow", 32'(bus.overflow), 32'(i == 16));
                    @(negedge clk);
                end
                bus.wr_en = 1'b0;
                #1;
                chk("ovf_clear", 32'(bus.overflow), 32'd0);
                chk("burst_final_level", 32'(bus.level), 32'd16);
            end
            begin
                check_frame(x, 3, 0, 0, 0);
                for (int i = 0; i < 16; i++) check_frame(burst[i], 3, 0, 0, 1);
            end
        join
        check_idle();

        // cfg_div change mid-frame only affects the next frame
        set_cfg(3, 0, 0);
        a = DATA_W'($urandom);
        b = DATA_W'($urandom);
        push(a);
        fork
            begin
                repeat (10) @(negedge clk);
                set_cfg(7, 0, 0);
                push(b);
            end
            begin
                check_frame(a, 3, 0, 0, 0);
                check_frame(b, 7, 0, 0, 1);
            end
        join
        check_idle();

        // Reset during data bit 3 with one word still queued
        set_cfg(3, 0, 0);
        c = DATA_W'($urandom);
        d = DATA_W'($urandom);
        e = DATA_W'($urandom);
        push(c);
        @(negedge clk);
        chk("pre_rst_start", 32'(bus.tx), 32'd0);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
        repeat (15) @(negedge clk);
        chk("pre_rst_bit3", 32'(bus.tx), 32'(c[3]));
        chk("pre_rst_level", 32'(bus.level), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_tx", 32'(bus.tx), 32'd1);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_level", 32'(bus.level), 32'd0);
        chk("mid_rst_empty", 32'(bus.empty), 32'd1);
        rst = 1'b0;
        set_cfg(2, 2, 0);
        push(e);
        check_frame(e, 2, 2, 0, 1);
        check_idle();

        // Randomized single frames
        for (int n = 0; n < 6; n++) begin
            div = int'($urandom_range(0, 3));
            par = int'($urandom_range(0, 3));
            s2  = int'($urandom_range(0, 1));
            x   = DATA_W'($urandom);
            set_cfg(div, par, s2);
            push(x);
            check_frame(x, div, par, s2, 1);
            check_idle();
        end

        // Randomized back-to-back burst of four
        div = int'($urandom_range(0, 2));
        par = int'($urandom_range(0, 3));
        s2  = int'($urandom_range(0, 1));
        set_cfg(div, par, s2);
        for (int i = 0; i < 4; i++) burst[i] = DATA_W'($urandom);
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    bus.wr_en   = 1'b1;
                    bus.wr_data = burst[i];
                end
                @(negedge clk);
                bus.wr_en = 1'b0;
            end
            begin
                check_frame(burst[0], div, par, s2, 0);
                for (int i = 1; i < 4; i++) check_frame(burst[i], div, par, s2, 1);
            end
        join
        check_idle();

`ifdef UART_TX_BREAK_EN
        begin
            int lo, hi;
            set_cfg(3, 0, 0);
            x = DATA_W'($urandom);
            @(negedge clk);
            bus.brk_req = 1'b1;
            bus.wr_en   = 1'b1;
            bus.wr_data = x;
            @(negedge clk);
            bus.wr_en = 1'b0;
            lo = 0;
            for (int i = 0; i < 50; i++) begin
                if (i != 0) @(negedge clk);
                if (bus.tx === 1'b0) lo++;
            end
            bus.brk_req = 1'b0;
            chk("break_low_cycles", 32'(lo), 32'd50);
            hi = 0;
            @(negedge clk);
            while (bus.tx === 1'b1 && hi < BUDGET) begin
                hi++;
                @(negedge clk);
            end
            chk("break_gap_min", 32'(hi >= 4 && hi < BUDGET), 32'd1);
            check_frame(x, 3, 0, 0, 2);
            check_idle();
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: observed no completion, expected summary before timeout");
        $fatal(1, "watchdog expired");
    end
endmodule
